// File: rtl/alu_share_pkg.sv
// Shared opcode, flag-index and tag definitions for the ALU share arbiter.
package alu_share_pkg;

  localparam logic [3:0] ADD     = 4'd0;
  localparam logic [3:0] SUB     = 4'd1;
  localparam logic [3:0] MUL     = 4'd2;
  localparam logic [3:0] ROL     = 4'd3;
  localparam logic [3:0] ROR     = 4'd4;
  localparam logic [3:0] SLT     = 4'd5;
  localparam logic [3:0] SGE     = 4'd6;
  localparam logic [3:0] AND     = 4'd7;
  localparam logic [3:0] IDLE_OP = 4'hF;

  localparam int unsigned CARRY = 3;
  localparam int unsigned ZERO  = 2;
  localparam int unsigned OVF   = 1;
  localparam int unsigned SIGN  = 0;

  localparam int unsigned MAX_REQ = 8;
  localparam int unsigned ID_W    = 3;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/alu_share_arbiter_rr.sv
// Combinational round-robin picker: first eligible index at or after the pointer, wrapping.
module rr_arbiter
  import alu_share_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] eligible_i,
  input  logic [PW-1:0]      ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [PW-1:0]      winner_o,
  output logic [PW-1:0]      ptr_next_o
);

  logic          found;
  logic [PW-1:0] pos;

  always_comb begin
    grant_o    = '0;
    winner_o   = '0;
    ptr_next_o = ptr_i;
    found      = 1'b0;
    pos        = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      pos = PW'((32'(ptr_i) + k) % NUM_REQ);
      if (!found && eligible_i[pos]) begin
        found         = 1'b1;
        grant_o[pos]  = 1'b1;
        winner_o      = pos;
        ptr_next_o    = PW'((32'(pos) + 1) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one fixed-latency ALU among NUM_REQ requesters with per-requester response buffers.
// Optional counters stat_issued/stat_stall are present when ALU_SHARE_STATS_EN is defined.
module alu_share_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned W       = 128,
  parameter int unsigned ALU_LAT = 2,
  parameter logic [3:0]  IDLE_OP = alu_share_pkg::IDLE_OP
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*4-1:0] req_opcode,
  input  logic [NUM_REQ*W-1:0] req_input1,
  input  logic [NUM_REQ*W-1:0] req_input2,
  input  logic [NUM_REQ*5-1:0] req_shift,
  output logic [3:0]           alu_opcode,
  output logic [W-1:0]         alu_input1,
  output logic [W-1:0]         alu_input2,
  output logic [4:0]           alu_shiftValue,
  input  logic [W-1:0]         alu_result,
  input  logic [3:0]           alu_flags,
  output logic [NUM_REQ-1:0]   rsp_valid,
  input  logic [NUM_REQ-1:0]   rsp_ready,
  output logic [NUM_REQ*W-1:0] rsp_result,
`ifdef ALU_SHARE_STATS_EN
  output logic [31:0]          stat_issued,
  output logic [31:0]          stat_stall,
`endif
  output logic [NUM_REQ*4-1:0] rsp_flags
);
  import alu_share_pkg::*;

  localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] busy_q, busy_d;
  logic [PW-1:0]      rr_ptr_q, ptr_next, winner;
  logic [NUM_REQ-1:0] eligible, grant, hs, rsp_pop;
  logic               hs_any;

  logic [3:0]         alu_opcode_q;
  logic [W-1:0]       alu_input1_q, alu_input2_q;
  logic [4:0]         alu_shift_q;
  logic [3:0]         sel_opcode;
  logic [W-1:0]       sel_in1, sel_in2;
  logic [4:0]         sel_shift;

  tag_t               tag_q [ALU_LAT+1];

  logic [NUM_REQ-1:0] rsp_valid_q;
  logic [W-1:0]       rsp_result_q [NUM_REQ];
  logic [3:0]         rsp_flags_q  [NUM_REQ];

  assign eligible = req_valid & ~busy_q;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .eligible_i (eligible),
    .ptr_i      (rr_ptr_q),
    .grant_o    (grant),
    .winner_o   (winner),
    .ptr_next_o (ptr_next)
  );

  assign req_ready = rst ? '0 : grant;
  assign hs        = req_valid & req_ready;
  assign hs_any    = |hs;
  assign rsp_pop   = rsp_valid_q & rsp_ready;
  // Issue and response can never hit the same index in one cycle: busy blocks re-issue.
  assign busy_d    = (busy_q | hs) & ~rsp_pop;

  always_comb begin
    sel_opcode = IDLE_OP;
    sel_in1    = '0;
    sel_in2    = '0;
    sel_shift  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (hs[i]) begin
        sel_opcode = req_opcode[4*i +: 4];
        sel_in1    = req_input1[W*i +: W];
        sel_in2    = req_input2[W*i +: W];
        sel_shift  = req_shift[5*i +: 5];
      end
    end
  end

  // Operands hold across idle cycles; only the opcode drops back to IDLE_OP.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_opcode_q <= IDLE_OP;
      alu_input1_q <= '0;
      alu_input2_q <= '0;
      alu_shift_q  <= '0;
    end else if (hs_any) begin
      alu_opcode_q <= sel_opcode;
      alu_input1_q <= sel_in1;
      alu_input2_q <= sel_in2;
      alu_shift_q  <= sel_shift;
    end else begin
      alu_opcode_q <= IDLE_OP;
    end
  end

  assign alu_opcode     = alu_opcode_q;
  assign alu_input1     = alu_input1_q;
  assign alu_input2     = alu_input2_q;
  assign alu_shiftValue = alu_shift_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q   <= '0;
      rr_ptr_q <= '0;
    end else begin
      busy_q <= busy_d;
      if (hs_any) begin
        rr_ptr_q <= ptr_next;
      end
    end
  end

  // Stage k describes the op whose alu_* inputs were presented k cycles ago.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k <= ALU_LAT; k++) begin
        tag_q[k] <= '0;
      end
    end else begin
      tag_q[0].valid <= hs_any;
      tag_q[0].id    <= ID_W'(winner);
      for (int unsigned k = 1; k <= ALU_LAT; k++) begin
        tag_q[k] <= tag_q[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        rsp_result_q[i] <= '0;
        rsp_flags_q[i]  <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (tag_q[ALU_LAT].valid && (tag_q[ALU_LAT].id == ID_W'(i))) begin
          rsp_valid_q[i]  <= 1'b1;
          rsp_result_q[i] <= alu_result;
          rsp_flags_q[i]  <= alu_flags;
        end else if (rsp_pop[i]) begin
          rsp_valid_q[i]  <= 1'b0;
          rsp_result_q[i] <= '0;
          rsp_flags_q[i]  <= '0;
        end
      end
    end
  end

  assign rsp_valid = rsp_valid_q;

  always_comb begin
    rsp_result = '0;
    rsp_flags  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      rsp_result[W*i +: W] = rsp_result_q[i];
      rsp_flags[4*i +: 4]  = rsp_flags_q[i];
    end
  end

`ifdef ALU_SHARE_STATS_EN
  logic [31:0] stat_issued_q, stat_stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_issued_q <= '0;
      stat_stall_q  <= '0;
    end else begin
      stat_issued_q <= stat_issued_q + {31'd0, hs_any};
      stat_stall_q  <= stat_stall_q + {31'd0, |(req_valid & busy_q)};
    end
  end

  assign stat_issued = stat_issued_q;
  assign stat_stall  = stat_stall_q;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural 2-cycle ALU attached.
module tb_alu_share_arbiter;
  import alu_share_pkg::*;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned W       = 128;

  logic                 clk;
  logic                 rst;
  logic [NUM_REQ-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NUM_REQ*4-1:0] req_opcode, rsp_flags;
  logic [NUM_REQ*W-1:0] req_input1, req_input2, rsp_result;
  logic [NUM_REQ*5-1:0] req_shift;
  logic [3:0]           alu_opcode, alu_flags;
  logic [W-1:0]         alu_input1, alu_input2, alu_result;
  logic [4:0]           alu_shiftValue;
`ifdef ALU_SHARE_STATS_EN
  logic [31:0]          stat_issued, stat_stall;
`endif

  int checks   = 0;
  int failures = 0;

  alu_share_arbiter #(.NUM_REQ(NUM_REQ), .W(W), .ALU_LAT(2), .IDLE_OP(4'hF)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_opcode     (req_opcode),
    .req_input1     (req_input1),
    .req_input2     (req_input2),
    .req_shift      (req_shift),
    .alu_opcode     (alu_opcode),
    .alu_input1     (alu_input1),
    .alu_input2     (alu_input2),
    .alu_shiftValue (alu_shiftValue),
    .alu_result     (alu_result),
    .alu_flags      (alu_flags),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_result     (rsp_result),
`ifdef ALU_SHARE_STATS_EN
    .stat_issued    (stat_issued),
    .stat_stall     (stat_stall),
`endif
    .rsp_flags      (rsp_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: two register stages, unknown opcodes give zero and keep old flags.
  logic [W-1:0] m_res, s1_res, s2_res;
  logic [W:0]   m_wide;
  logic [3:0]   m_flg, s1_flg, s2_flg;

  always_comb begin
    m_res  = '0;
    m_wide = '0;
    m_flg  = s1_flg;
    case (alu_opcode)
      ADD: begin
        m_wide = {1'b0, alu_input1} + {1'b0, alu_input2};
        m_res  = m_wide[W-1:0];
        m_flg  = {m_wide[W], m_res == '0,
                  (alu_input1[W-1] == alu_input2[W-1]) && (m_res[W-1] != alu_input1[W-1]), m_res[W-1]};
      end
      SUB: begin
        m_wide = {1'b0, alu_input1} - {1'b0, alu_input2};
        m_res  = m_wide[W-1:0];
        m_flg  = {m_wide[W], m_res == '0,
                  (alu_input1[W-1] != alu_input2[W-1]) && (m_res[W-1] != alu_input1[W-1]), m_res[W-1]};
      end
      MUL: begin
        m_res = alu_input1 * alu_input2;
        m_flg = {1'b0, m_res == '0, 1'b0, m_res[W-1]};
      end
      ROL: begin
        m_res = (alu_input1 << alu_shiftValue) | (alu_input1 >> (W - 32'(alu_shiftValue)));
        m_flg = {1'b0, m_res == '0, 1'b0, m_res[W-1]};
      end
      ROR: begin
        m_res = (alu_input1 >> alu_shiftValue) | (alu_input1 << (W - 32'(alu_shiftValue)));
        m_flg = {1'b0, m_res == '0, 1'b0, m_res[W-1]};
      end
      AND: begin
        m_res = alu_input1 & alu_input2;
        m_flg = {1'b0, m_res == '0, 1'b0, m_res[W-1]};
      end
      default: m_res = '0;
    endcase
  end

  always @(posedge clk) begin
    if (rst) begin
      s1_res <= '0; s1_flg <= '0;
      s2_res <= '0; s2_flg <= '0;
    end else begin
      s1_res <= m_res;  s1_flg <= m_flg;
      s2_res <= s1_res; s2_flg <= s1_flg;
    end
  end

  assign alu_result = s2_res;
  assign alu_flags  = s2_flg;

  typedef struct {
    int unsigned  id;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [4:0]   sh;
    logic [W-1:0] res;
    logic [3:0]   flg;
  } vec_t;

  vec_t       tv [8];
  logic [3:0] rr_exp [12];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic drive_op(input int unsigned id, input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [4:0] sh);
    req_valid[id]          = 1'b1;
    req_opcode[4*id +: 4]  = op;
    req_input1[W*id +: W]  = a;
    req_input2[W*id +: W]  = b;
    req_shift[5*id +: 5]   = sh;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = '0;
    next_cycle();
    next_cycle();
    rst = 1'b0;
    settle();
    chk4("rst_req_ready", req_ready, 4'h0);
    chk4("rst_rsp_valid", rsp_valid, 4'h0);
    chk("rst_rsp_result", W'(|rsp_result), W'(0));
    chk("rst_rsp_flags", W'(rsp_flags), W'(0));
    chk4("rst_alu_opcode", alu_opcode, 4'hF);
    chk("rst_alu_input1", alu_input1, '0);
    chk("rst_alu_input2", alu_input2, '0);
    chk("rst_alu_shift", W'(alu_shiftValue), W'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned id;
    logic [3:0]  oh;

    tv[0] = '{0, ADD, W'(5),            W'(7),  5'd0, W'(12),             4'b0000};
    tv[1] = '{1, SUB, W'(0),            W'(1),  5'd0, {W{1'b1}},          4'b1001};
    tv[2] = '{2, MUL, W'(3),            W'(3),  5'd0, W'(9),              4'b0000};
    tv[3] = '{3, ROL, W'(1),            W'(0),  5'd4, W'(16),             4'b0000};
    tv[4] = '{0, AND, W'(8'hF0),        W'(8'h3C), 5'd0, W'(8'h30),       4'b0000};
    tv[5] = '{1, ADD, {W{1'b1}},        W'(1),  5'd0, W'(0),              4'b1100};
    tv[6] = '{2, ROR, W'(1),            W'(0),  5'd1, {1'b1, {(W-1){1'b0}}}, 4'b0001};
    tv[7] = '{3, ADD, {1'b0, {(W-1){1'b1}}}, W'(1), 5'd0, {1'b1, {(W-1){1'b0}}}, 4'b0011};

    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0001,
               4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0001, 4'b0010};

    rst        = 1'b1;
    req_valid  = '0;
    rsp_ready  = '0;
    req_opcode = '0;
    req_input1 = '0;
    req_input2 = '0;
    req_shift  = '0;
    do_reset();

    // Single ops: issue timing, 4-cycle response, busy blocking, release next cycle.
    for (int v = 0; v < 8; v++) begin
      id = tv[v].id;
      oh = 4'(1) << id;
      next_cycle();
      drive_op(id, tv[v].op, tv[v].a, tv[v].b, tv[v].sh);
      settle();
      chk4("vec_grant", req_ready, oh);
      next_cycle();
      req_valid = '0;
      settle();
      chk4("vec_alu_opcode", alu_opcode, tv[v].op);
      chk("vec_alu_input1", alu_input1, tv[v].a);
      chk("vec_alu_input2", alu_input2, tv[v].b);
      chk("vec_alu_shift", W'(alu_shiftValue), W'(tv[v].sh));
      next_cycle();
      settle();
      chk4("vec_idle_opcode", alu_opcode, 4'hF);
      next_cycle();
      settle();
      chk4("vec_rsp_early", rsp_valid, 4'h0);
      next_cycle();
      req_valid[id] = 1'b1;
      settle();
      chk4("vec_rsp_valid", rsp_valid, oh);
      chk("vec_result", rsp_result[W*id +: W], tv[v].res);
      chk4("vec_flags", rsp_flags[4*id +: 4], tv[v].flg);
      chk4("vec_busy_block", req_ready, 4'h0);
      rsp_ready[id] = 1'b1;
      next_cycle();
      rsp_ready = '0;
      settle();
      chk4("vec_rsp_cleared", rsp_valid, 4'h0);
      chk("vec_buf_cleared", rsp_result[W*id +: W], '0);
      chk4("vec_reeligible", req_ready, oh);
      req_valid = '0;
    end

    // Round robin with every requester always valid and consuming at once.
    do_reset();
    rsp_ready = '1;
    for (int unsigned i = 0; i < NUM_REQ; i++) drive_op(i, ADD, W'(i + 1), W'(1), 5'd0);
    for (int c = 0; c < 12; c++) begin
      settle();
      chk4("rr_grant", req_ready, rr_exp[c]);
      next_cycle();
    end
    req_valid = '0;
    repeat (6) next_cycle();
    settle();
    chk4("rr_drained", rsp_valid, 4'h0);

    // Backpressure on requester 1 while requester 2 proceeds.
    do_reset();
    rsp_ready = 4'b0100;
    drive_op(1, SUB, W'(0), W'(1), 5'd0);
    settle();
    chk4("bp_grant1", req_ready, 4'b0010);
    for (int c = 1; c <= 13; c++) begin
      next_cycle();
      if (c == 5) drive_op(2, ADD, W'(2), W'(2), 5'd0);
      else req_valid[2] = 1'b0;
      if (c == 13) rsp_ready[1] = 1'b1;
      settle();
      chk4("bp_ready1_blocked", 4'(req_ready[1]), 4'h0);
      if (c == 5) chk4("bp_grant2", req_ready, 4'b0100);
      if (c == 9) begin
        chk4("bp_rsp2_valid", 4'(rsp_valid[2]), 4'h1);
        chk("bp_rsp2_result", rsp_result[W*2 +: W], W'(4));
      end
      if (c >= 4) begin
        chk4("bp_rsp1_held", 4'(rsp_valid[1]), 4'h1);
        chk("bp_rsp1_result", rsp_result[W*1 +: W], {W{1'b1}});
        chk4("bp_rsp1_flags", rsp_flags[4*1 +: 4], 4'b1001);
      end
    end
    next_cycle();
    req_valid = '0;
    rsp_ready = '0;
    settle();
    chk4("bp_rsp1_consumed", 4'(rsp_valid[1]), 4'h0);
`ifdef ALU_SHARE_STATS_EN
    chk("stat_issued", W'(stat_issued), W'(2));
    chk("stat_stall", W'(stat_stall), W'(13));
`endif

    // Routing of two overlapping ops to their own buffers.
    do_reset();
    drive_op(3, ROL, W'(1), W'(0), 5'd4);
    settle();
    chk4("rt_grant3", req_ready, 4'b1000);
    next_cycle();
    req_valid = '0;
    drive_op(0, AND, W'(8'hF0), W'(8'h3C), 5'd0);
    settle();
    chk4("rt_grant0", req_ready, 4'b0001);
    next_cycle();
    req_valid = '0;
    next_cycle();
    settle();
    chk4("rt_none_c3", rsp_valid, 4'h0);
    next_cycle();
    settle();
    chk4("rt_valid_c4", rsp_valid, 4'b1000);
    chk("rt_buf3", rsp_result[W*3 +: W], W'(16));
    next_cycle();
    settle();
    chk4("rt_valid_c5", rsp_valid, 4'b1001);
    chk("rt_buf0", rsp_result[W*0 +: W], W'(8'h30));
    chk("rt_buf3_hold", rsp_result[W*3 +: W], W'(16));
    rsp_ready = '1;
    next_cycle();
    rsp_ready = '0;
    settle();
    chk4("rt_drained", rsp_valid, 4'h0);

    // Reset while an op is in flight.
    do_reset();
    drive_op(2, MUL, W'(3), W'(3), 5'd0);
    settle();
    chk4("mr_grant", req_ready, 4'b0100);
    next_cycle();
    req_valid = '0;
    next_cycle();
    rst = 1'b1;
    settle();
    chk4("mr_ready_in_rst", req_ready, 4'h0);
    next_cycle();
    rst = 1'b0;
    settle();
    chk4("mr_alu_opcode", alu_opcode, 4'hF);
    chk("mr_alu_input1", alu_input1, '0);
    chk("mr_alu_input2", alu_input2, '0);
    for (int c = 0; c < 6; c++) begin
      settle();
      chk4("mr_no_rsp", rsp_valid, 4'h0);
      next_cycle();
    end
    drive_op(2, MUL, W'(3), W'(3), 5'd0);
    drive_op(3, ADD, W'(1), W'(1), 5'd0);
    settle();
    chk4("mr_ptr_reset", req_ready, 4'b0100);
    next_cycle();
    req_valid[2] = 1'b0;
    settle();
    chk4("mr_grant3", req_ready, 4'b1000);
    next_cycle();
    req_valid = '0;
    next_cycle();
    next_cycle();
    settle();
    chk4("mr_rsp_valid", rsp_valid, 4'b0100);
    chk("mr_result", rsp_result[W*2 +: W], W'(9));
    chk4("mr_flags", rsp_flags[4*2 +: 4], 4'b0000);
    rsp_ready = '1;
    repeat (3) next_cycle();
    rsp_ready = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
